xiyiji_program_ctrl: RTL and testbench

Wash-program sequencer for the washing-machine design. After a start request it runs a fixed phase sequence: fill, timed wash with forward/stop/reverse/stop agitation, drain, spin, done. It drives the valve and motor outputs and a remaining-seconds count. It supports pause and emergency stop, and raises an alarm on sensor timeout or sensor fault.

---
 rtl/xiyiji_program_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_xiyiji_program_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/xiyiji_program_ctrl.sv
// xiyiji_program_ctrl
// Wash-program sequencer: IDLE -> FILL -> WASH -> DRAIN -> SPIN -> DONE, with
// ALARM as a sink that only rst leaves. WASH agitates forward/stop/reverse/stop.
// A 1-second tick comes from a prescaler that runs only while a phase is active
// and not paused.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               level; its rising edge starts a program (IDLE/DONE)
//   pause               level; freezes an active phase, actuators forced off
//   emergency           level; forces ALARM from any state except IDLE
//   wash_time[5:0]      wash seconds, latched on start
//   full, empty         water-level sensors
//   fill, drain         inlet / drain valves
//   zheng, fan, spin    motor forward / reverse / spin mode
//   state[2:0]          state code
//   remain[5:0]         remaining wash seconds
//   done, alarm         program complete / fault latched
module xiyiji_program_ctrl #(
  parameter int TICK_DIV = 50,
  parameter int RUN_S    = 4,
  parameter int STOP_S   = 1,
  parameter int SPIN_S   = 6,
  parameter int TMO_S    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       emergency,
  input  logic [5:0] wash_time,
  input  logic       full,
  input  logic       empty,
  output logic       fill,
  output logic       drain,
  output logic       zheng,
  output logic       fan,
  output logic       spin,
  output logic [2:0] state,
  output logic [5:0] remain,
  output logic       done,
  output logic       alarm
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WASH  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_SPIN  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ALARM = 3'd6;

  // Agitation subphases, in cycling order (increment wraps S2 -> F)
  localparam logic [1:0] SUB_F  = 2'd0;
  localparam logic [1:0] SUB_S1 = 2'd1;
  localparam logic [1:0] SUB_R  = 2'd2;
  localparam logic [1:0] SUB_S2 = 2'd3;

  localparam int CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (TMO_S > SPIN_S) ? TMO_S : SPIN_S;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PMAX = (RUN_S > STOP_S) ? RUN_S : STOP_S;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_S - 1);
  localparam logic [TW-1:0] SPIN_LAST = TW'(SPIN_S - 1);
  localparam logic [PW-1:0] RUN_LAST  = PW'(RUN_S - 1);
  localparam logic [PW-1:0] STOP_LAST = PW'(STOP_S - 1);

  logic [2:0]    state_q, state_d;
  logic [5:0]    remain_q, remain_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;       // ticks spent in current state
  logic [1:0]    sub_q, sub_d;
  logic [PW-1:0] sub_cnt_q, sub_cnt_d;
  logic          start_q;
  logic          fill_q, fill_d, drain_q, drain_d, zheng_q, zheng_d;
  logic          fan_q, fan_d, spin_q, spin_d, done_q, done_d, alarm_q, alarm_d;

  logic          start_edge, active, tick, fault, sub_last;

  always_comb begin
    start_edge = start & ~start_q;
    active     = (state_q == S_FILL) || (state_q == S_WASH) ||
                 (state_q == S_DRAIN) || (state_q == S_SPIN);
    tick       = active & ~pause & (cnt_q == CNT_LAST);
    fault      = full & empty;
    sub_last   = (sub_q == SUB_F || sub_q == SUB_R) ? (sub_cnt_q == RUN_LAST)
                                                    : (sub_cnt_q == STOP_LAST);

    state_d   = state_q;
    remain_d  = remain_q;
    tmr_d     = tmr_q;
    sub_d     = sub_q;
    sub_cnt_d = sub_cnt_q;

    // Prescaler holds while paused, idles at 0 outside active phases
    if (!active)    cnt_d = '0;
    else if (pause) cnt_d = cnt_q;
    else if (tick)  cnt_d = '0;
    else            cnt_d = cnt_q + 1'b1;

    if (tick) tmr_d = tmr_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge && wash_time != 6'd0) begin
          state_d  = S_FILL;
          remain_d = wash_time;
        end
      end
      S_FILL: begin
        if (!pause) begin
          if (fault)                          state_d = S_ALARM;
          else if (full)                      state_d = S_WASH;
          else if (tick && tmr_q == TMO_LAST) state_d = S_ALARM;
        end
      end
      S_WASH: begin
        if (tick) begin
          remain_d = remain_q - 6'd1;
          if (remain_q == 6'd1) state_d = S_DRAIN;
          if (sub_last) begin
            sub_d     = sub_q + 2'd1;
            sub_cnt_d = '0;
          end else begin
            sub_cnt_d = sub_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!pause) begin
          if (fault)                          state_d = S_ALARM;
          else if (empty)                     state_d = S_SPIN;
          else if (tick && tmr_q == TMO_LAST) state_d = S_ALARM;
        end
      end
      S_SPIN: begin
        if (tick && tmr_q == SPIN_LAST) state_d = S_DONE;
      end
      default: state_d = state_q;   // ALARM (and unused codes) hold
    endcase

    if (emergency && state_q != S_IDLE) state_d = S_ALARM;

    // Every state entry restarts the prescaler and per-state timers
    if (state_d != state_q) begin
      cnt_d     = '0;
      tmr_d     = '0;
      sub_d     = SUB_F;
      sub_cnt_d = '0;
    end

    // Outputs are computed from next-state values so they align with state_q
    fill_d  = (state_d == S_FILL) & ~pause;
    drain_d = ((state_d == S_DRAIN) || (state_d == S_SPIN)) & ~pause;
    zheng_d = (((state_d == S_WASH) && (sub_d == SUB_F)) || (state_d == S_SPIN)) & ~pause;
    fan_d   = (state_d == S_WASH) & (sub_d == SUB_R) & ~pause;
    spin_d  = (state_d == S_SPIN) & ~pause;
    done_d  = (state_d == S_DONE);
    alarm_d = (state_d == S_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      remain_q  <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      sub_q     <= SUB_F;
      sub_cnt_q <= '0;
      // Track start during reset so a level already high gives no edge
      start_q   <= start;
      fill_q    <= 1'b0;
      drain_q   <= 1'b0;
      zheng_q   <= 1'b0;
      fan_q     <= 1'b0;
      spin_q    <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      sub_q     <= sub_d;
      sub_cnt_q <= sub_cnt_d;
      start_q   <= start;
      fill_q    <= fill_d;
      drain_q   <= drain_d;
      zheng_q   <= zheng_d;
      fan_q     <= fan_d;
      spin_q    <= spin_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
    end
  end

  assign state  = state_q;
  assign remain = remain_q;
  assign fill   = fill_q;
  assign drain  = drain_q;
  assign zheng  = zheng_q;
  assign fan    = fan_q;
  assign spin   = spin_q;
  assign done   = done_q;
  assign alarm  = alarm_q;

endmodule

// File: tb/tb_xiyiji_program_ctrl.sv
// Directed bench for xiyiji_program_ctrl with TICK_DIV=4.
// Observed bus layout: {state[2:0], remain[5:0], fill, drain, zheng, fan, spin, done, alarm}
module tb_xiyiji_program_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       emergency = 1'b0;
  logic [5:0] wash_time = 6'd0;
  logic       full = 1'b0;
  logic       empty = 1'b0;
  logic       fill, drain, zheng, fan, spin, done, alarm;
  logic [2:0] state;
  logic [5:0] remain;
  logic [15:0] obs, exp_v;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  xiyiji_program_ctrl #(.TICK_DIV(4), .RUN_S(4), .STOP_S(1), .SPIN_S(6), .TMO_S(30)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .emergency(emergency),
    .wash_time(wash_time), .full(full), .empty(empty),
    .fill(fill), .drain(drain), .zheng(zheng), .fan(fan), .spin(spin),
    .state(state), .remain(remain), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  assign obs = {state, remain, fill, drain, zheng, fan, spin, done, alarm};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0; pause = 1'b0; emergency = 1'b0; full = 1'b0; empty = 1'b0;
    do_reset();
    chk_cnt++;
    if (obs !== 16'h0000) $display("FAIL reset obs=%h exp=%h", obs, 16'h0000);
    else pass_cnt++;
  endtask

  task automatic test_nominal();
    do_reset();
    wash_time = 6'd10; start = 1'b1;
    step();
    start = 1'b0;
    exp_v = {3'd1, 6'd10, 7'b1000000};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL nom_fill_entry obs=%h exp=%h", obs, exp_v); else pass_cnt++;
    step(); step();
    full = 1'b1;
    step();
    full = 1'b0;
    for (int i = 0; i < 40; i++) begin
      exp_v = {3'd2, 6'(10 - i / 4), 1'b0, 1'b0, (i < 16), (i >= 20 && i < 36), 3'b000};
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL nom_wash[%0d] obs=%h exp=%h", i, obs, exp_v); else pass_cnt++;
      step();
    end
    exp_v = {3'd3, 6'd0, 7'b0100000};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL nom_drain obs=%h exp=%h", obs, exp_v); else pass_cnt++;
    step(); step(); step(); step();
    empty = 1'b1;
    step();
    for (int i = 0; i < 24; i++) begin
      exp_v = {3'd4, 6'd0, 7'b0110100};
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL nom_spin[%0d] obs=%h exp=%h", i, obs, exp_v); else pass_cnt++;
      step();
    end
    empty = 1'b0;
    exp_v = {3'd5, 6'd0, 7'b0000010};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL nom_done obs=%h exp=%h", obs, exp_v); else pass_cnt++;
    // restart from DONE
    wash_time = 6'd3; start = 1'b1;
    step();
    start = 1'b0;
    exp_v = {3'd1, 6'd3, 7'b1000000};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL done_restart obs=%h exp=%h", obs, exp_v); else pass_cnt++;
    full = 1'b1;
    step();
    full = 1'b0;
    exp_v = {3'd2, 6'd3, 7'b0010000};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL restart_wash obs=%h exp=%h", obs, exp_v); else pass_cnt++;
    for (int i = 0; i < 12; i++) step();
    exp_v = {3'd3, 6'd0, 7'b0100000};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL restart_drain obs=%h exp=%h", obs, exp_v); else pass_cnt++;
    full = 1'b1; empty = 1'b1;
    step();
    full = 1'b0; empty = 1'b0;
    exp_v = {3'd6, 6'd0, 7'b0000001};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL drain_sensor_fault obs=%h exp=%h", obs, exp_v); else pass_cnt++;
  endtask

  task automatic test_zero_wash();
    do_reset();
    wash_time = 6'd0; start = 1'b1;
    step();
    chk_cnt++;
    if (obs !== 16'h0000) $display("FAIL zero_wash obs=%h exp=%h", obs, 16'h0000); else pass_cnt++;
    step();
    chk_cnt++;
    if (state !== 3'd0) $display("FAIL zero_wash_hold state=%0d exp=0", state); else pass_cnt++;
    // start held high across reset must not count as an edge
    wash_time = 6'd5;
    do_reset();
    step(); step(); step();
    start = 1'b0;
    chk_cnt++;
    if (state !== 3'd0) $display("FAIL start_held_reset state=%0d exp=0", state); else pass_cnt++;
  endtask

  task automatic test_fill_timeout();
    do_reset();
    wash_time = 6'd5; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 120; k++) begin
      step();
      exp_v = {3'd1, 6'd5, 7'b1000000};
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL fill_wait[%0d] obs=%h exp=%h", k, obs, exp_v); else pass_cnt++;
    end
    step();
    exp_v = {3'd6, 6'd5, 7'b0000001};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL fill_timeout obs=%h exp=%h", obs, exp_v); else pass_cnt++;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL alarm_ignores_start obs=%h exp=%h", obs, exp_v); else pass_cnt++;
  endtask

  task automatic test_pause_wash();
    do_reset();
    wash_time = 6'd10; start = 1'b1;
    step();
    start = 1'b0; full = 1'b1;
    step();
    full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_v = {3'd2, 6'(10 - i / 4), 1'b0, 1'b0, (i < 16), (i >= 20 && i < 36), 3'b000};
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL pre_pause[%0d] obs=%h exp=%h", i, obs, exp_v); else pass_cnt++;
      if (i == 5) pause = 1'b1;
      step();
    end
    for (int p = 0; p < 37; p++) begin
      exp_v = {3'd2, 6'd9, 7'b0000000};
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL paused[%0d] obs=%h exp=%h", p, obs, exp_v); else pass_cnt++;
      if (p == 36) pause = 1'b0;
      step();
    end
    for (int i = 6; i < 40; i++) begin
      exp_v = {3'd2, 6'(10 - i / 4), 1'b0, 1'b0, (i < 16), (i >= 20 && i < 36), 3'b000};
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL post_pause[%0d] obs=%h exp=%h", i, obs, exp_v); else pass_cnt++;
      step();
    end
    exp_v = {3'd3, 6'd0, 7'b0100000};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL pause_drain obs=%h exp=%h", obs, exp_v); else pass_cnt++;
  endtask

  task automatic test_emergency_spin();
    empty = 1'b1;
    step();
    exp_v = {3'd4, 6'd0, 7'b0110100};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL emg_spin_entry obs=%h exp=%h", obs, exp_v); else pass_cnt++;
    step(); step(); step();
    emergency = 1'b1;
    step();
    emergency = 1'b0; empty = 1'b0;
    exp_v = {3'd6, 6'd0, 7'b0000001};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL emg_alarm obs=%h exp=%h", obs, exp_v); else pass_cnt++;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL emg_start_ignored obs=%h exp=%h", obs, exp_v); else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cnt++;
    if (obs !== 16'h0000) $display("FAIL emg_rst obs=%h exp=%h", obs, 16'h0000); else pass_cnt++;
    step();
    chk_cnt++;
    if (obs !== 16'h0000) $display("FAIL emg_rst_hold obs=%h exp=%h", obs, 16'h0000); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_wash();
    test_fill_timeout();
    test_pause_wash();
    test_emergency_spin();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
